// File: rtl/nand_page_reader.sv
// NAND page-read sequencer: command 00h, three address cycles, busy wait, then 512 byte strobes.
// Optional NAND_RB_SYNC_EN: F_RB passes through a 2-flop synchronizer before the FSM sees it.
module nand_page_reader #(
    parameter int unsigned TWB_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] page_addr,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       F_CLE,
    output logic       F_ALE,
    output logic       F_WEN,
    output logic       F_REN,
    input  logic       F_RB,
    output logic [7:0] io_out,
    output logic       io_oe,
    input  logic [7:0] io_in,
    output logic       cnt_setZ,
    output logic       cnt_run,
    input  logic       cnt_flag
);

    localparam int unsigned TWB_W = (TWB_MAX > 1) ? $clog2(TWB_MAX) : 1;

    typedef enum logic [3:0] {
        IDLE, CMD_L, CMD_H, ADR_L, ADR_H, WAIT_LOW, WAIT_HIGH, RD_L, RD_H, DONE
    } state_t;

    state_t           state, state_n;
    logic [1:0]       adr_idx, adr_idx_n;
    logic [TWB_W-1:0] twb_cnt, twb_cnt_n;
    logic [8:0]       page_q, page_n;
    logic             rb;

    logic       busy_n, done_n, rd_valid_n, cle_n, ale_n, wen_n, ren_n;
    logic       io_oe_n, setz_n, run_n;
    logic [7:0] rd_data_n, io_out_n;

`ifdef NAND_RB_SYNC_EN
    // Two-flop synchronizer, idles at "ready" so a reset does not fake a busy edge.
    logic [1:0] rb_sync;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rb_sync <= 2'b11;
        else     rb_sync <= {rb_sync[0], F_RB};
    end
    assign rb = rb_sync[1];
`else
    assign rb = F_RB;
`endif

    // State, sequencing counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            adr_idx  <= 2'd0;
            twb_cnt  <= '0;
            page_q   <= 9'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            F_CLE    <= 1'b0;
            F_ALE    <= 1'b0;
            F_WEN    <= 1'b1;
            F_REN    <= 1'b1;
            io_out   <= 8'h00;
            io_oe    <= 1'b0;
            cnt_setZ <= 1'b0;
            cnt_run  <= 1'b0;
        end else begin
            state    <= state_n;
            adr_idx  <= adr_idx_n;
            twb_cnt  <= twb_cnt_n;
            page_q   <= page_n;
            busy     <= busy_n;
            done     <= done_n;
            rd_data  <= rd_data_n;
            rd_valid <= rd_valid_n;
            F_CLE    <= cle_n;
            F_ALE    <= ale_n;
            F_WEN    <= wen_n;
            F_REN    <= ren_n;
            io_out   <= io_out_n;
            io_oe    <= io_oe_n;
            cnt_setZ <= setz_n;
            cnt_run  <= run_n;
        end
    end

    // Next state, then outputs decoded from the next state so they line up with it.
    always_comb begin
        state_n    = state;
        adr_idx_n  = adr_idx;
        twb_cnt_n  = twb_cnt;
        page_n     = page_q;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        rd_data_n  = rd_data;
        rd_valid_n = 1'b0;
        cle_n      = 1'b0;
        ale_n      = 1'b0;
        wen_n      = 1'b1;
        ren_n      = 1'b1;
        io_out_n   = io_out;
        io_oe_n    = 1'b0;
        setz_n     = 1'b0;
        run_n      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CMD_L;
                    page_n  = page_addr;
                end
            end
            CMD_L: state_n = CMD_H;
            CMD_H: begin
                state_n   = ADR_L;
                adr_idx_n = 2'd0;
            end
            ADR_L: state_n = ADR_H;
            ADR_H: begin
                if (adr_idx == 2'd2) begin
                    state_n   = WAIT_LOW;
                    twb_cnt_n = '0;
                end else begin
                    state_n   = ADR_L;
                    adr_idx_n = adr_idx + 2'd1;
                end
            end
            WAIT_LOW: begin
                // Proceed anyway if the flash never reports busy within TWB_MAX cycles.
                if (!rb || twb_cnt == TWB_W'(TWB_MAX - 1)) state_n = WAIT_HIGH;
                else twb_cnt_n = twb_cnt + TWB_W'(1);
            end
            WAIT_HIGH: if (rb) state_n = RD_L;
            RD_L:      state_n = RD_H;
            RD_H:      state_n = cnt_flag ? DONE : RD_L;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
        case (state_n)
            CMD_L: begin
                cle_n    = 1'b1;
                wen_n    = 1'b0;
                io_oe_n  = 1'b1;
                io_out_n = 8'h00;
                setz_n   = 1'b1;
            end
            CMD_H: begin
                cle_n    = 1'b1;
                io_oe_n  = 1'b1;
                io_out_n = 8'h00;
            end
            ADR_L, ADR_H: begin
                ale_n   = 1'b1;
                wen_n   = (state_n == ADR_H);
                io_oe_n = 1'b1;
                case (adr_idx_n)
                    2'd1:    io_out_n = page_q[7:0];
                    2'd2:    io_out_n = {7'b0, page_q[8]};
                    default: io_out_n = 8'h00;
                endcase
            end
            RD_L: ren_n = 1'b0;
            RD_H: begin
                rd_data_n  = io_in;
                rd_valid_n = 1'b1;
                run_n      = 1'b1;
            end
            DONE:    done_n = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nand_page_reader.sv
// Randomized page-read bench with byte-counter, flash and cycle-timing reference models.
module tb_nand_page_reader;

    localparam int TWB = 15;
`ifdef NAND_RB_SYNC_EN
    localparam int RB_LAT = 2;
`else
    localparam int RB_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] page_addr = 9'd0;
    logic       busy, done, rd_valid, F_CLE, F_ALE, F_WEN, F_REN, io_oe;
    logic       cnt_setZ, cnt_run, cnt_flag;
    logic       F_RB = 1'b1;
    logic [7:0] rd_data, io_out, io_in;

    int checks = 0;
    int errors = 0;

    nand_page_reader #(.TWB_MAX(TWB)) dut (
        .clk(clk), .rst(rst), .start(start), .page_addr(page_addr),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .F_CLE(F_CLE), .F_ALE(F_ALE), .F_WEN(F_WEN), .F_REN(F_REN), .F_RB(F_RB),
        .io_out(io_out), .io_oe(io_oe), .io_in(io_in),
        .cnt_setZ(cnt_setZ), .cnt_run(cnt_run), .cnt_flag(cnt_flag)
    );

    always #5 clk = ~clk;

    // Saturating 9-bit byte counter the sequencer drives.
    logic [8:0] cnt_q = 9'd0;
    always @(posedge clk) begin
        if (cnt_setZ)                    cnt_q <= 9'd0;
        else if (cnt_run && cnt_q != 511) cnt_q <= cnt_q + 9'd1;
    end
    assign cnt_flag = (cnt_q == 9'd511);

    // Flash data model: byte k of the page reads as k[7:0] ^ seed.
    logic [7:0] seed = 8'h00;
    int         byte_idx = 0;
    logic       ren_prev = 1'b1;
    always @(negedge clk) begin
        if (F_CLE)                 byte_idx = 0;
        else if (F_REN && !ren_prev) byte_idx++;
        ren_prev = F_REN;
    end
    assign io_in = 8'(byte_idx) ^ seed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'h00);
        check({tag, "_cle"}, 32'(F_CLE), 32'd0);
        check({tag, "_ale"}, 32'(F_ALE), 32'd0);
        check({tag, "_wen"}, 32'(F_WEN), 32'd1);
        check({tag, "_ren"}, 32'(F_REN), 32'd1);
        check({tag, "_io_out"}, 32'(io_out), 32'h00);
        check({tag, "_io_oe"}, 32'(io_oe), 32'd0);
        check({tag, "_setz"}, 32'(cnt_setZ), 32'd0);
        check({tag, "_run"}, 32'(cnt_run), 32'd0);
    endtask

    // Flash RB as driven in cycle x after acceptance (0 = CMD_L cycle).
    function automatic bit raw_rb(input int x, input int fall, input int rise);
        return !(x >= fall && x < rise);
    endfunction

    // First RD_L cycle: wait-low exits on busy seen or after TWB cycles, wait-high exits on ready.
    function automatic int calc_rd_start(input int fall, input int rise);
        int c = 8;
        while (raw_rb(c - RB_LAT, fall, rise) && c != 8 + TWB - 1) c++;
        c++;
        while (!raw_rb(c - RB_LAT, fall, rise)) c++;
        return c + 1;
    endfunction

    task automatic run_page(input logic [8:0] addr, input int fall, input int rise,
                            input int abort_off, input bit noise);
        int rds, edone, nvalid, abort_at;
        logic [7:0] adr_b [4];
        bit exp_rv, exp_ren;
        rds      = calc_rd_start(fall, rise);
        edone    = rds + 1024;
        abort_at = (abort_off < 0) ? -1 : rds + abort_off;
        adr_b[0] = 8'h00;
        adr_b[1] = 8'h00;
        adr_b[2] = addr[7:0];
        adr_b[3] = {7'b0, addr[8]};
        nvalid   = 0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        seed      = 8'($urandom_range(0, 255));
        start     = 1'b1;
        page_addr = addr;
        F_RB      = 1'b1;
        for (int c = 0; c <= edone + 1; c++) begin
            @(negedge clk);
            start = (noise && c < edone) ? 1'($urandom_range(0, 1)) : 1'b0;
            F_RB  = raw_rb(c, fall, rise);
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_vals("abort");
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                F_RB  = 1'b1;
                return;
            end
            if (c == edone + 1) begin
                check("end_busy", 32'(busy), 32'd0);
                check("end_done", 32'(done), 32'd0);
            end else begin
                exp_rv  = (c >= rds && c < edone && (c - rds) % 2 == 1);
                exp_ren = !(c >= rds && c < edone && (c - rds) % 2 == 0);
                check("busy", 32'(busy), 32'd1);
                check("done", 32'(done), 32'(c == edone));
                check("io_oe", 32'(io_oe), 32'(c < 8));
                check("setz", 32'(cnt_setZ), 32'(c == 0));
                check("rd_valid", 32'(rd_valid), 32'(exp_rv));
                check("ren", 32'(F_REN), 32'(exp_ren));
                check("run", 32'(cnt_run), 32'(exp_rv));
                if (c < 8) begin
                    check("cle", 32'(F_CLE), 32'(c < 2));
                    check("ale", 32'(F_ALE), 32'(c >= 2));
                    check("wen", 32'(F_WEN), 32'(c % 2));
                    check("io_out", 32'(io_out), 32'(adr_b[c / 2]));
                end else begin
                    check("cle_off", 32'(F_CLE | F_ALE), 32'd0);
                end
                if (rd_valid) begin
                    check("rd_data", 32'(rd_data), 32'(8'(nvalid) ^ seed));
                    check("cnt_idx", 32'(cnt_q), 32'(nvalid));
                    nvalid++;
                end
            end
        end
        check("nvalid", 32'(nvalid), 32'd512);
        check("cnt_end", 32'(cnt_q), 32'd511);
    endtask

    initial begin
        int f;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("idle");

        run_page(9'h1A5, 10, 60, -1, 1'b0);
        run_page(9'($urandom_range(0, 511)), 8, 9, -1, 1'b0);
        run_page(9'($urandom_range(0, 511)), 0, 0, -1, 1'b0);
        run_page(9'($urandom_range(0, 511)), 9, 30, 200, 1'b0);
        run_page(9'h0FF, 12, 40, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            f = int'($urandom_range(8, 26));
            run_page(9'($urandom_range(0, 511)), f, f + int'($urandom_range(1, 60)), -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
